cpu_run_ctrl: RTL and testbench

- Parametrised run-control and debug unit that sits beside the pipelined CPU core inside the top-level wrapper.
- Holds the core in reset for a programmable interval, then gates execution through a stall line.
- Supports halt on request, single-step and N address breakpoints.
- Keeps cycle and retire counters and a circular trace of the last retired PC/opcode pairs for bench and debug readout.

---
 rtl/cpu_run_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run-control and debug unit for the pipelined core: reset hold, halt/step/breakpoint
// sequencing, cycle/retire counters and a circular trace of retired PC/opcode pairs.
module cpu_run_ctrl #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned OP_WIDTH    = 8,
  parameter int unsigned NUM_BP      = 4,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned RESET_HOLD  = 4,
  localparam int unsigned BpIdxW     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int unsigned TrIdxW     = $clog2(TRACE_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   core_pc,
  input  logic [OP_WIDTH-1:0]   core_op,
  input  logic                  core_retire,
  input  logic                  dbg_halt_req,
  input  logic                  dbg_resume_req,
  input  logic                  dbg_step_req,
  input  logic                  bp_wr_en,
  input  logic [BpIdxW-1:0]     bp_wr_idx,
  input  logic [PC_WIDTH-1:0]   bp_wr_addr,
  input  logic                  bp_wr_valid,
  input  logic [TrIdxW-1:0]     trace_rd_idx,
  output logic                  core_reset_n,
  output logic                  core_stall,
  output logic                  halted,
  output logic [1:0]            halt_cause,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  retire_count,
  output logic [PC_WIDTH-1:0]   trace_pc,
  output logic [OP_WIDTH-1:0]   trace_op,
  output logic [TrIdxW:0]       trace_count
);

  localparam int unsigned HoldW = $clog2(RESET_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);
  localparam logic [TrIdxW:0] TraceFull = (TrIdxW + 1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {StHold, StRun, StHalt, StStep} state_e;

  state_e                         state_q;
  logic [HoldW-1:0]               hold_cnt_q;
  logic                           core_reset_n_q;
  logic [1:0]                     halt_cause_q;
  logic [PC_WIDTH-1:0]            bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0]              bp_valid_q;
  logic [CNT_WIDTH-1:0]           cycle_count_q;
  logic [CNT_WIDTH-1:0]           retire_count_q;
  logic [PC_WIDTH+OP_WIDTH-1:0]   trace_mem [TRACE_DEPTH];
  logic [TrIdxW-1:0]              wptr_q;
  logic [TrIdxW:0]                trace_count_q;
  logic [TrIdxW-1:0]              rd_ptr;
  logic                           bp_hit;
  logic                           retire_ok;
  logic                           active;

  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < int'(NUM_BP); i++) begin
      if (bp_valid_q[i] && (core_pc == bp_addr_q[i])) bp_hit = 1'b1;
    end
    bp_hit = bp_hit & core_retire;
  end

  // A retire in the cycle that triggers a halt/step completion is still taken.
  always_comb begin
    core_stall = 1'b1;
    case (state_q)
      StRun:   core_stall = bp_hit | dbg_halt_req;
      StStep:  core_stall = core_retire;
      default: core_stall = 1'b1;
    endcase
  end

  assign active    = (state_q == StRun) || (state_q == StStep);
  assign retire_ok = core_retire & active;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StHold;
      hold_cnt_q     <= '0;
      core_reset_n_q <= 1'b0;
      halt_cause_q   <= 2'd0;
    end else begin
      unique case (state_q)
        StHold: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (hold_cnt_q == HoldLast) begin
            core_reset_n_q <= 1'b1;
            if (dbg_halt_req) begin
              state_q      <= StHalt;
              halt_cause_q <= 2'd1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (bp_hit) begin
            state_q      <= StHalt;
            halt_cause_q <= 2'd2;
          end else if (dbg_halt_req) begin
            state_q      <= StHalt;
            halt_cause_q <= 2'd1;
          end
        end
        StHalt: begin
          if (!dbg_halt_req) begin
            if (dbg_resume_req) begin
              state_q      <= StRun;
              halt_cause_q <= 2'd0;
            end else if (dbg_step_req) begin
              state_q      <= StStep;
              halt_cause_q <= 2'd0;
            end
          end
        end
        StStep: begin
          if (core_retire) begin
            state_q      <= StHalt;
            halt_cause_q <= 2'd3;
          end else if (dbg_halt_req) begin
            state_q      <= StHalt;
            halt_cause_q <= 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bp_valid_q <= '0;
      for (int i = 0; i < int'(NUM_BP); i++) bp_addr_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BP); i++) begin
        if (bp_wr_en && (bp_wr_idx == BpIdxW'(i))) begin
          bp_addr_q[i]  <= bp_wr_addr;
          bp_valid_q[i] <= bp_wr_valid;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count_q  <= '0;
      retire_count_q <= '0;
      wptr_q         <= '0;
      trace_count_q  <= '0;
    end else begin
      if (active) cycle_count_q <= cycle_count_q + 1'b1;
      if (retire_ok) begin
        retire_count_q <= retire_count_q + 1'b1;
        wptr_q         <= wptr_q + 1'b1;
        if (trace_count_q != TraceFull) trace_count_q <= trace_count_q + 1'b1;
      end
    end
  end

  // Trace storage carries no reset; entries beyond trace_count are never meaningful.
  always_ff @(posedge clock) begin
    if (retire_ok) trace_mem[wptr_q] <= {core_pc, core_op};
  end

  assign rd_ptr = wptr_q - TrIdxW'(1) - trace_rd_idx;
  assign {trace_pc, trace_op} = trace_mem[rd_ptr];

  assign core_reset_n = core_reset_n_q;
  assign halted       = (state_q == StHalt);
  assign halt_cause   = halt_cause_q;
  assign cycle_count  = cycle_count_q;
  assign retire_count = retire_count_q;
  assign trace_count  = trace_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios then random traffic, all checked each cycle
// against a behavioural model of the run-control rules.
module tb_cpu_run_ctrl;

  localparam int MHold = 0;
  localparam int MRun  = 1;
  localparam int MHalt = 2;
  localparam int MStep = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] core_pc = '0;
  logic [7:0]  core_op = '0;
  logic        core_retire = 1'b0;
  logic        dbg_halt_req = 1'b0;
  logic        dbg_resume_req = 1'b0;
  logic        dbg_step_req = 1'b0;
  logic        bp_wr_en = 1'b0;
  logic [1:0]  bp_wr_idx = '0;
  logic [31:0] bp_wr_addr = '0;
  logic        bp_wr_valid = 1'b0;
  logic [2:0]  trace_rd_idx = '0;
  logic        core_reset_n;
  logic        core_stall;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [3:0]  cycle_count;
  logic [3:0]  retire_count;
  logic [31:0] trace_pc;
  logic [7:0]  trace_op;
  logic [3:0]  trace_count;

  int total = 0;
  int bad   = 0;

  // Model: mode, elapsed hold cycles, cause, unbounded counters, newest-first trace queue.
  int          m_mode;
  int          m_hold;
  int          m_cause;
  int          m_cycles;
  int          m_retires;
  logic [39:0] m_trace [$];
  logic [31:0] m_bp_a [4];
  bit          m_bp_v [4];

  always #5 clock = ~clock;

  cpu_run_ctrl #(
    .PC_WIDTH(32), .OP_WIDTH(8), .NUM_BP(4), .TRACE_DEPTH(8), .CNT_WIDTH(4), .RESET_HOLD(4)
  ) dut (
    .clock(clock), .reset(reset), .core_pc(core_pc), .core_op(core_op),
    .core_retire(core_retire), .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
    .dbg_step_req(dbg_step_req), .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx),
    .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid), .trace_rd_idx(trace_rd_idx),
    .core_reset_n(core_reset_n), .core_stall(core_stall), .halted(halted),
    .halt_cause(halt_cause), .cycle_count(cycle_count), .retire_count(retire_count),
    .trace_pc(trace_pc), .trace_op(trace_op), .trace_count(trace_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit();
    for (int i = 0; i < 4; i++) begin
      if (m_bp_v[i] && core_pc == m_bp_a[i]) return core_retire;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = MHold; m_hold = 0; m_cause = 0; m_cycles = 0; m_retires = 0;
    m_trace.delete();
    for (int i = 0; i < 4; i++) m_bp_v[i] = 1'b0;
  endtask

  task automatic check_all();
    bit exp_stall;
    int n;
    case (m_mode)
      MRun:    exp_stall = m_hit() || dbg_halt_req;
      MStep:   exp_stall = core_retire;
      default: exp_stall = 1'b1;
    endcase
    n = (m_trace.size() > 8) ? 8 : m_trace.size();
    chk("core_reset_n", core_reset_n, m_mode != MHold);
    chk("core_stall", core_stall, exp_stall);
    chk("halted", halted, m_mode == MHalt);
    chk("halt_cause", halt_cause, m_cause);
    chk("cycle_count", cycle_count, m_cycles % 16);
    chk("retire_count", retire_count, m_retires % 16);
    chk("trace_count", trace_count, n);
    if (int'(trace_rd_idx) < n) chk("trace_entry", {trace_pc, trace_op}, m_trace[trace_rd_idx]);
  endtask

  task automatic clock_edge();
    bit hit, ret_ok;
    @(posedge clock);
    if (reset) begin
      hit    = m_hit();
      ret_ok = core_retire && (m_mode == MRun || m_mode == MStep);
      if (m_mode == MRun || m_mode == MStep) m_cycles++;
      if (ret_ok) begin
        m_retires++;
        m_trace.push_front({core_pc, core_op});
        if (m_trace.size() > 8) void'(m_trace.pop_back());
      end
      case (m_mode)
        MHold: begin
          m_hold++;
          if (m_hold == 4) begin
            if (dbg_halt_req) begin m_mode = MHalt; m_cause = 1; end
            else m_mode = MRun;
          end
        end
        MRun: begin
          if (hit) begin m_mode = MHalt; m_cause = 2; end
          else if (dbg_halt_req) begin m_mode = MHalt; m_cause = 1; end
        end
        MHalt: begin
          if (!dbg_halt_req && dbg_resume_req) begin m_mode = MRun; m_cause = 0; end
          else if (!dbg_halt_req && dbg_step_req) begin m_mode = MStep; m_cause = 0; end
        end
        default: begin
          if (core_retire) begin m_mode = MHalt; m_cause = 3; end
          else if (dbg_halt_req) begin m_mode = MHalt; m_cause = 1; end
        end
      endcase
      if (bp_wr_en) begin
        m_bp_a[bp_wr_idx] = bp_wr_addr;
        m_bp_v[bp_wr_idx] = bp_wr_valid;
      end
    end
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    check_all();
  endtask

  task automatic cycle();
    settle();
    clock_edge();
  endtask

  task automatic idle();
    core_retire = 0; dbg_resume_req = 0; dbg_step_req = 0; bp_wr_en = 0;
  endtask

  task automatic retire_pc(input logic [31:0] pc);
    core_retire = 1; core_pc = pc; core_op = pc[7:0] ^ 8'hA5;
  endtask

  // Asserts reset mid-cycle, checks the immediate clear, releases just after a rising edge.
  task automatic do_reset();
    idle();
    dbg_halt_req = 0;
    reset = 0;
    #1;
    model_reset();
    chk("rst_core_reset_n", core_reset_n, 1'b0);
    chk("rst_cycle_count", cycle_count, 4'd0);
    chk("rst_retire_count", retire_count, 4'd0);
    chk("rst_trace_count", trace_count, 4'd0);
    repeat (2) cycle();
    reset = 1;
  endtask

  initial begin
    trace_rd_idx = 0;
    do_reset();

    bp_wr_en = 1; bp_wr_idx = 2; bp_wr_addr = 32'h40; bp_wr_valid = 1;
    cycle();
    bp_wr_idx = 3; bp_wr_addr = 32'h44;
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("hold_core_reset_n", core_reset_n, 1'b0);
      chk("hold_stall", core_stall, 1'b1);
      clock_edge();
      bp_wr_en = 0;
    end
    retire_pc(32'h38);
    settle();
    chk("run_core_reset_n", core_reset_n, 1'b1);
    chk("run_stall", core_stall, 1'b0);
    clock_edge();
    chk("first_cycle_count", cycle_count, 4'd1);
    retire_pc(32'h3C);
    cycle();
    retire_pc(32'h40);
    settle();
    chk("bp_stall", core_stall, 1'b1);
    clock_edge();
    retire_pc(32'h44);
    settle();
    chk("bp_halted", halted, 1'b1);
    chk("bp_cause", halt_cause, 2'd2);
    chk("bp_retires", retire_count, 4'd3);
    chk("bp_trace0", trace_pc, 32'h40);
    clock_edge();

    idle(); dbg_step_req = 1;
    cycle();
    idle(); retire_pc(32'h44);
    settle();
    chk("step_stall", core_stall, 1'b1);
    clock_edge();
    retire_pc(32'h48);
    settle();
    chk("step_cause", halt_cause, 2'd3);
    chk("step_retires", retire_count, 4'd4);
    clock_edge();

    idle(); dbg_resume_req = 1;
    cycle();
    idle(); dbg_halt_req = 1; retire_pc(32'h50);
    settle();
    chk("req_stall", core_stall, 1'b1);
    clock_edge();
    idle(); dbg_resume_req = 1;
    cycle();
    settle();
    chk("req_blocks_exit", halted, 1'b1);
    chk("req_cause", halt_cause, 2'd1);
    dbg_halt_req = 0;
    clock_edge();
    idle();
    settle();
    chk("resume_halted", halted, 1'b0);
    chk("resume_cause", halt_cause, 2'd0);
    clock_edge();

    for (int i = 0; i < 11; i++) begin
      retire_pc(32'(4 * i));
      cycle();
    end
    idle(); trace_rd_idx = 0;
    settle();
    chk("trace_full", trace_count, 4'd8);
    chk("trace_idx0", trace_pc, 32'h28);
    clock_edge();
    trace_rd_idx = 7;
    settle();
    chk("trace_idx7", trace_pc, 32'hC);
    clock_edge();

    do_reset();
    repeat (4) cycle();
    repeat (17) cycle();
    chk("cycle_wrap", cycle_count, 4'd1);
    do_reset();

    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(0, 11) == 0) dbg_halt_req = ~dbg_halt_req;
      dbg_resume_req = ($urandom_range(0, 5) == 0);
      dbg_step_req   = ($urandom_range(0, 5) == 0);
      core_retire    = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 4))
        0: core_pc = 32'h38;
        1: core_pc = 32'h40;
        2: core_pc = 32'h44;
        default: core_pc = $urandom() & 32'hFC;
      endcase
      core_op      = 8'($urandom());
      trace_rd_idx = 3'($urandom());
      if ($urandom_range(0, 9) == 0) begin
        bp_wr_en    = 1;
        bp_wr_idx   = 2'($urandom());
        bp_wr_addr  = ($urandom_range(0, 1) == 1) ? 32'h40 : ($urandom() & 32'hFC);
        bp_wr_valid = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
